// File: rtl/ecc_pkg.sv
// Shared constants for the ECC datapath RAM transfer logic.
//   DATA_W / ADDR_W : RAM word and address widths
//   WORDS           : words per operand (3 x 192 = 576-bit operand)
//   CNT_W           : width of the word counters (must be able to hold WORDS)
//   DIR_LOAD/STORE  : read_write_command encoding
//   xfer_state_e    : transfer controller FSM states
package ecc_pkg;
  localparam int DATA_W = 192;
  localparam int ADDR_W = 6;
  localparam int WORDS  = 3;
  localparam int CNT_W  = $clog2(WORDS + 1);

  localparam logic DIR_LOAD  = 1'b0;  // outer -> inner
  localparam logic DIR_STORE = 1'b1;  // inner -> outer

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } xfer_state_e;
endpackage

// File: rtl/ram_transfer_controller.sv
// Copies one WORDS-word operand between the outer (host) RAM and the inner
// (arithmetic) RAM. Reads issue back to back from the source RAM; each read's
// data is written to the destination RAM in the following cycle. A one-cycle
// interrupt follows the last write.
// Ports:
//   clk, rst                 : clock, async active-high reset
//   cmd_transfer             : start request, honoured only in IDLE
//   read_write_command       : 0 load (outer->inner), 1 store (inner->outer)
//   read_address/write_address : source / destination base addresses
//   interupt_ram_transfer    : one-cycle completion pulse
//   outer_* / inner_*        : sync RAM ports (read data valid 1 cycle after rd_en)
module ram_transfer_controller
  import ecc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_transfer,
  input  logic              read_write_command,
  input  logic [ADDR_W-1:0] read_address,
  input  logic [ADDR_W-1:0] write_address,
  output logic              interupt_ram_transfer,
  output logic              outer_rd_en,
  output logic [ADDR_W-1:0] outer_rd_addr,
  input  logic [DATA_W-1:0] outer_rd_data,
  output logic              outer_wr_en,
  output logic [ADDR_W-1:0] outer_wr_addr,
  output logic [DATA_W-1:0] outer_wr_data,
  output logic              inner_rd_en,
  output logic [ADDR_W-1:0] inner_rd_addr,
  input  logic [DATA_W-1:0] inner_rd_data,
  output logic              inner_wr_en,
  output logic [ADDR_W-1:0] inner_wr_addr,
  output logic [DATA_W-1:0] inner_wr_data
);

  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  xfer_state_e       state_q, state_d;
  logic              dir_q, dir_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  // Set the cycle after a read: that read's data is on the source rd_data now.
  logic              wr_pend_q, wr_pend_d;

  logic              rd_go, wr_go;
  logic [ADDR_W-1:0] rd_addr, wr_addr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_LOAD;
      src_q     <= '0;
      dst_q     <= '0;
      rd_cnt_q  <= '0;
      wr_cnt_q  <= '0;
      wr_pend_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rd_cnt_q  <= rd_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_pend_q <= wr_pend_d;
    end
  end

  assign rd_go   = (state_q == ST_XFER) && (rd_cnt_q < WORDS_C);
  assign wr_go   = wr_pend_q;
  // Address arithmetic wraps modulo 2**ADDR_W by construction.
  assign rd_addr = src_q + ADDR_W'(rd_cnt_q);
  assign wr_addr = dst_q + ADDR_W'(wr_cnt_q);

  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rd_cnt_d  = rd_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_pend_d = rd_go;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_transfer) begin
          dir_d    = read_write_command;
          src_d    = read_address;
          dst_d    = write_address;
          rd_cnt_d = '0;
          wr_cnt_d = '0;
          state_d  = ST_XFER;
        end
      end
      ST_XFER: begin
        if (rd_go) rd_cnt_d = rd_cnt_q + ONE_C;
        if (wr_go) begin
          wr_cnt_d = wr_cnt_q + ONE_C;
          if (wr_cnt_q == LAST_C) state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign interupt_ram_transfer = (state_q == ST_DONE);

  // Only the source read port and destination write port ever toggle;
  // addresses and write data are held at zero while a port is idle.
  assign outer_rd_en   = rd_go && (dir_q == DIR_LOAD);
  assign inner_rd_en   = rd_go && (dir_q == DIR_STORE);
  assign inner_wr_en   = wr_go && (dir_q == DIR_LOAD);
  assign outer_wr_en   = wr_go && (dir_q == DIR_STORE);

  assign outer_rd_addr = outer_rd_en ? rd_addr : '0;
  assign inner_rd_addr = inner_rd_en ? rd_addr : '0;
  assign inner_wr_addr = inner_wr_en ? wr_addr : '0;
  assign outer_wr_addr = outer_wr_en ? wr_addr : '0;

  // Write data is the source RAM output passed straight through; the RAM's
  // own read register is the only pipeline stage on the data path.
  assign inner_wr_data = inner_wr_en ? outer_rd_data : '0;
  assign outer_wr_data = outer_wr_en ? inner_rd_data : '0;

endmodule

// File: tb/tb_ram_transfer_controller.sv
module tb_ram_transfer_controller;
  import ecc_pkg::*;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_transfer = 1'b0;
  logic              read_write_command = 1'b0;
  logic [ADDR_W-1:0] read_address = '0;
  logic [ADDR_W-1:0] write_address = '0;
  logic              irq;
  logic              outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en;
  logic [ADDR_W-1:0] outer_rd_addr, outer_wr_addr, inner_rd_addr, inner_wr_addr;
  logic [DATA_W-1:0] outer_rd_data, outer_wr_data, inner_rd_data, inner_wr_data;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_transfer_controller dut (
    .clk(clk), .rst(rst),
    .cmd_transfer(cmd_transfer), .read_write_command(read_write_command),
    .read_address(read_address), .write_address(write_address),
    .interupt_ram_transfer(irq),
    .outer_rd_en(outer_rd_en), .outer_rd_addr(outer_rd_addr), .outer_rd_data(outer_rd_data),
    .outer_wr_en(outer_wr_en), .outer_wr_addr(outer_wr_addr), .outer_wr_data(outer_wr_data),
    .inner_rd_en(inner_rd_en), .inner_rd_addr(inner_rd_addr), .inner_rd_data(inner_rd_data),
    .inner_wr_en(inner_wr_en), .inner_wr_addr(inner_wr_addr), .inner_wr_data(inner_wr_data)
  );

  // Behavioural sync RAMs (1-cycle read latency) plus reference copies.
  logic [DATA_W-1:0] outer_mem [0:63];
  logic [DATA_W-1:0] inner_mem [0:63];
  logic [DATA_W-1:0] ref_outer [0:63];
  logic [DATA_W-1:0] ref_inner [0:63];

  always @(posedge clk) begin
    if (outer_rd_en) outer_rd_data <= outer_mem[outer_rd_addr];
    if (outer_wr_en) outer_mem[outer_wr_addr] <= outer_wr_data;
  end
  always @(posedge clk) begin
    if (inner_rd_en) inner_rd_data <= inner_mem[inner_rd_addr];
    if (inner_wr_en) inner_mem[inner_wr_addr] <= inner_wr_data;
  end

  // Monitor: interrupt cycles, strobes on the wrong ports, address traces.
  logic             exp_dir = DIR_LOAD;
  int               irq_cnt = 0;
  int               bad_cnt = 0;
  logic [ADDR_W-1:0] rd_log[$];
  logic [ADDR_W-1:0] wr_log[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (irq) irq_cnt++;
      if (exp_dir == DIR_LOAD ? (outer_wr_en || inner_rd_en) : (inner_wr_en || outer_rd_en)) bad_cnt++;
      if (outer_rd_en) rd_log.push_back(outer_rd_addr);
      if (inner_rd_en) rd_log.push_back(inner_rd_addr);
      if (outer_wr_en) wr_log.push_back(outer_wr_addr);
      if (inner_wr_en) wr_log.push_back(inner_wr_addr);
    end
  end

  function automatic logic [DATA_W-1:0] rnd_word();
    logic [DATA_W-1:0] w;
    for (int i = 0; i < DATA_W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  function automatic int mem_diffs();
    int d = 0;
    for (int i = 0; i < 64; i++) begin
      if (outer_mem[i] !== ref_outer[i]) d++;
      if (inner_mem[i] !== ref_inner[i]) d++;
    end
    return d;
  endfunction

  // Operand copy as the spec defines it: WORDS words, addresses mod 64.
  task automatic model_copy(input logic dir, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] ws);
    for (int i = 0; i < WORDS; i++) begin
      if (dir == DIR_LOAD) ref_inner[(ws + i) % 64] = ref_outer[(rs + i) % 64];
      else                 ref_outer[(ws + i) % 64] = ref_inner[(rs + i) % 64];
    end
  endtask

  task automatic clear_mon();
    irq_cnt = 0; bad_cnt = 0; rd_log.delete(); wr_log.delete();
  endtask

  // Issue a command at the current negedge and wait (bounded) for the
  // interrupt. lat = negedges after acceptance when it was seen, -1 if never.
  // mode 1: pulse cmd mid-transfer; mode 2: scramble inputs mid-transfer.
  task automatic run_xfer(input logic dir, input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] ws,
                          input int mode, output int lat);
    exp_dir = dir;
    read_write_command = dir; read_address = rs; write_address = ws;
    cmd_transfer = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) begin
        cmd_transfer = 1'b0;
        if (mode == 2) begin
          read_write_command = ~dir; read_address = ~rs; write_address = ws ^ 6'h15;
        end
      end
      if (mode == 1 && n == 2) cmd_transfer = 1'b1;
      if (mode == 1 && n == 3) cmd_transfer = 1'b0;
      if (irq) begin lat = n; break; end
    end
    model_copy(dir, rs, ws);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if ({outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en} !== 4'b0) begin
      failures++; $display("FAIL reset_en got=%b want=0000", {outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en}); end
    checks++; if ({outer_rd_addr, outer_wr_addr, inner_rd_addr, inner_wr_addr} !== '0) begin
      failures++; $display("FAIL reset_addr got=%h want=0", {outer_rd_addr, outer_wr_addr, inner_rd_addr, inner_wr_addr}); end
    checks++; if ((outer_wr_data | inner_wr_data) !== '0) begin
      failures++; $display("FAIL reset_wdata got=%h want=0", outer_wr_data | inner_wr_data); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b want=0", irq); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_load();
    int lat;
    clear_mon();
    run_xfer(DIR_LOAD, 6'd3, 6'd3, 0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL load_latency got=%0d want=5", lat); end
    repeat (3) @(negedge clk);
    checks++; if (irq_cnt != 1) begin failures++; $display("FAIL load_irq_count got=%0d want=1", irq_cnt); end
    checks++; if (bad_cnt != 0) begin failures++; $display("FAIL load_wrong_port got=%0d want=0", bad_cnt); end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL load_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_store();
    int lat;
    clear_mon();
    run_xfer(DIR_STORE, 6'h21, 6'h21, 0, lat);
    checks++; if (lat != 5) begin failures++; $display("FAIL store_latency got=%0d want=5", lat); end
    repeat (3) @(negedge clk);
    checks++; if (irq_cnt != 1) begin failures++; $display("FAIL store_irq_count got=%0d want=1", irq_cnt); end
    checks++; if (bad_cnt != 0) begin failures++; $display("FAIL store_wrong_port got=%0d want=0", bad_cnt); end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL store_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_wrap();
    int lat;
    int bad_addr;
    clear_mon();
    run_xfer(DIR_LOAD, 6'h3E, 6'h3F, 0, lat);
    repeat (3) @(negedge clk);
    bad_addr = 0;
    checks++; if (rd_log.size() != WORDS || wr_log.size() != WORDS) begin
      failures++; $display("FAIL wrap_count got=%0d/%0d want=%0d/%0d", rd_log.size(), wr_log.size(), WORDS, WORDS);
    end else begin
      for (int i = 0; i < WORDS; i++) begin
        if (rd_log[i] != 6'((62 + i) % 64)) bad_addr++;
        if (wr_log[i] != 6'((63 + i) % 64)) bad_addr++;
      end
      checks++; if (bad_addr != 0) begin failures++; $display("FAIL wrap_addr got=%0d bad want=0", bad_addr); end
    end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL wrap_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    clear_mon();
    run_xfer(DIR_LOAD, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1, lat1);
    @(negedge clk);  // first IDLE cycle after the interrupt
    run_xfer(DIR_LOAD, 6'd6, 6'd6, 0, lat2);
    checks++; if (lat1 != 5) begin failures++; $display("FAIL b2b_lat1 got=%0d want=5", lat1); end
    checks++; if (lat2 != 5) begin failures++; $display("FAIL b2b_lat2 got=%0d want=5", lat2); end
    repeat (8) @(negedge clk);
    checks++; if (irq_cnt != 2) begin failures++; $display("FAIL b2b_irq_count got=%0d want=2", irq_cnt); end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL b2b_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  task automatic test_input_change();
    int lat;
    for (int k = 0; k < 4; k++) begin
      clear_mon();
      run_xfer(logic'(k & 1), 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 2, lat);
      repeat (3) @(negedge clk);
      checks++; if (lat != 5) begin failures++; $display("FAIL chg_latency[%0d] got=%0d want=5", k, lat); end
      checks++; if (bad_cnt != 0 || irq_cnt != 1) begin
        failures++; $display("FAIL chg_ports[%0d] got bad=%0d irq=%0d want 0/1", k, bad_cnt, irq_cnt); end
      checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL chg_mem[%0d] got=%0d diffs want=0", k, mem_diffs()); end
    end
  endtask

  task automatic test_reset_midop();
    logic [ADDR_W-1:0] ws;
    int lat;
    ws = 6'($urandom_range(0, 63));
    clear_mon();
    exp_dir = DIR_LOAD;
    read_write_command = DIR_LOAD; read_address = 6'($urandom_range(0, 63)); write_address = ws;
    cmd_transfer = 1'b1;
    @(negedge clk); cmd_transfer = 1'b0;
    repeat (2) @(negedge clk);     // now in the cycle of the 2nd write
    checks++; if (inner_wr_en !== 1'b1) begin failures++; $display("FAIL rst_pre_write got=%b want=1", inner_wr_en); end
    rst = 1'b1;
    #1;
    checks++; if ({outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en} !== 4'b0) begin
      failures++; $display("FAIL rst_mid_en got=%b want=0000", {outer_rd_en, outer_wr_en, inner_rd_en, inner_wr_en}); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL rst_mid_irq got=%b want=0", irq); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (irq_cnt != 0) begin failures++; $display("FAIL rst_no_irq got=%0d want=0", irq_cnt); end
    // Partially written destination is undefined: adopt whatever is there.
    for (int i = 0; i < WORDS; i++) ref_inner[(ws + i) % 64] = inner_mem[(ws + i) % 64];
    clear_mon();
    run_xfer(DIR_STORE, 6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 0, lat);
    repeat (3) @(negedge clk);
    checks++; if (lat != 5 || irq_cnt != 1) begin
      failures++; $display("FAIL rst_after got lat=%0d irq=%0d want 5/1", lat, irq_cnt); end
    checks++; if (mem_diffs() != 0) begin failures++; $display("FAIL rst_after_mem got=%0d diffs want=0", mem_diffs()); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      outer_mem[i] = rnd_word(); inner_mem[i] = rnd_word();
      ref_outer[i] = outer_mem[i]; ref_inner[i] = inner_mem[i];
    end
    test_reset();
    test_load();
    test_store();
    test_wrap();
    test_back_to_back();
    test_input_change();
    test_reset_midop();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
